// File: rtl/png_pkg.sv
// Shared types and widths for the PNG stream arbiter slice.
package png_pkg;

  localparam int PNG_W_BITS   = 14;
  localparam int PNG_H_BITS   = 32;
  localparam int PNG_EXP_BITS = PNG_W_BITS + PNG_H_BITS;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] a;
  } pixel_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } arb_state_e;

endpackage

// File: rtl/png_tag_fifo.sv
// Small show-ahead FIFO of channel tags: the head is visible combinationally so
// a pop can hand the tag to the output stage in the same cycle.
module png_tag_fifo
  import png_pkg::*;
#(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH) + 1;
  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);
  localparam logic [AW-1:0]   LAST_C  = AW'(DEPTH - 1);

  logic [W-1:0]    mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CNTW-1:0] count_reg;
  logic            do_push;
  logic            do_pop;

  assign full    = (count_reg == DEPTH_C);
  assign empty   = (count_reg == '0);
  // A push while full or a pop while empty is dropped.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr_reg];

  // Tag storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push/pop keeps the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= (wr_ptr_reg == LAST_C) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= (rd_ptr_reg == LAST_C) ? '0 : rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/png_stream_arbiter.sv
// Shares one hard_png decoder between NCH byte-stream requesters. A requester
// owns the decoder input for a whole file; decoder outputs are tagged with the
// channel that supplied the file, using a queue of granted channels.
module png_stream_arbiter
  import png_pkg::*;
#(
  parameter int  NCH        = 4,
  parameter int  TAGQ_DEPTH = 4,
  localparam int CW         = $clog2(NCH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        req_valid,
  output logic [NCH-1:0]        req_ready,
  input  logic [NCH*8-1:0]      req_byte,
  input  logic [NCH-1:0]        req_last,
  output logic                  dec_ivalid,
  input  logic                  dec_iready,
  output logic [7:0]            dec_ibyte,
  input  logic                  dec_newframe,
  input  logic [1:0]            dec_colortype,
  input  logic [PNG_W_BITS-1:0] dec_width,
  input  logic [PNG_H_BITS-1:0] dec_height,
  input  logic                  dec_ovalid,
  input  logic [31:0]           dec_pixel,
  output logic                  onewframe,
  output logic [1:0]            ocolortype,
  output logic [PNG_W_BITS-1:0] owidth,
  output logic [PNG_H_BITS-1:0] oheight,
  output logic                  ovalid,
  output logic [31:0]           opixel,
  output logic [CW-1:0]         ochan,
  output logic                  oframe_done,
  output logic                  busy,
  output logic                  tag_err
);

  arb_state_e              state_reg, state_next;
  logic [CW-1:0]           grant_reg, grant_next;
  logic [CW-1:0]           rr_ptr_reg, rr_ptr_next;
  logic [CW-1:0]           sel_chan;
  logic                    sel_found;
  logic [CW:0]             scan_idx;
  logic                    q_push, q_full, q_empty;
  logic [CW-1:0]           q_head;
  logic                    beat;
  logic [7:0]              ch_byte [NCH];

  logic                    onewframe_reg;
  logic [1:0]              ocolortype_reg;
  logic [PNG_W_BITS-1:0]   owidth_reg;
  logic [PNG_H_BITS-1:0]   oheight_reg;
  logic                    ovalid_reg;
  pixel_t                  opixel_reg;
  logic [CW-1:0]           cur_chan_reg;
  logic                    oframe_done_reg;
  logic                    tag_err_reg;
  logic [PNG_EXP_BITS-1:0] exp_reg;
  logic [PNG_EXP_BITS-1:0] pcnt_reg;
  logic [PNG_EXP_BITS-1:0] pcnt_inc;

  // Per-channel byte lanes and the grant-steered ready fan-out.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign ch_byte[gi]   = req_byte[8*gi +: 8];
    assign req_ready[gi] = (state_reg == STREAM) && (grant_reg == CW'(gi)) && dec_iready;
  end

  // The granted channel drives the decoder straight through, no register.
  assign dec_ivalid = (state_reg == STREAM) && req_valid[grant_reg];
  assign dec_ibyte  = (state_reg == STREAM) ? ch_byte[grant_reg] : 8'h00;
  assign beat       = dec_ivalid && dec_iready;
  assign busy       = (state_reg == STREAM) || !q_empty;

  // Round-robin pick: scan from the farthest offset inward so the channel
  // closest to rr_ptr is the one left standing.
  always_comb begin
    sel_found = 1'b0;
    sel_chan  = '0;
    scan_idx  = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      scan_idx = {1'b0, rr_ptr_reg} + (CW+1)'(k);
      if (scan_idx >= (CW+1)'(NCH)) begin
        scan_idx = scan_idx - (CW+1)'(NCH);
      end
      if (req_valid[scan_idx[CW-1:0]]) begin
        sel_found = 1'b1;
        sel_chan  = scan_idx[CW-1:0];
      end
    end
  end

  // Grant FSM: one idle cycle to grant, then hold the grant until the file ends.
  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    rr_ptr_next = rr_ptr_reg;
    q_push      = 1'b0;
    case (state_reg)
      IDLE: begin
        // A full tag queue would lose the owner of a future frame, so wait.
        if (sel_found && !q_full) begin
          grant_next = sel_chan;
          q_push     = 1'b1;
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (beat && req_last[grant_reg]) begin
          state_next  = IDLE;
          rr_ptr_next = (grant_reg == CW'(NCH - 1)) ? '0 : grant_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state, grant and round-robin pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      grant_reg  <= '0;
      rr_ptr_reg <= '0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  // Channels in grant order; the decoder emits frames in that same order.
  png_tag_fifo #(
    .W     (CW),
    .DEPTH (TAGQ_DEPTH)
  ) u_tagq (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .wdata (sel_chan),
    .pop   (dec_newframe),
    .rdata (q_head),
    .full  (q_full),
    .empty (q_empty)
  );

  assign pcnt_inc = pcnt_reg + 1'b1;

  // Output register stage, frame ownership and pixel counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      onewframe_reg   <= 1'b0;
      ocolortype_reg  <= '0;
      owidth_reg      <= '0;
      oheight_reg     <= '0;
      ovalid_reg      <= 1'b0;
      opixel_reg      <= '0;
      cur_chan_reg    <= '0;
      oframe_done_reg <= 1'b0;
      tag_err_reg     <= 1'b0;
      exp_reg         <= '0;
      pcnt_reg        <= '0;
    end else begin
      onewframe_reg   <= dec_newframe;
      ovalid_reg      <= dec_ovalid;
      opixel_reg      <= dec_pixel;
      oframe_done_reg <= 1'b0;
      if (dec_newframe) begin
        ocolortype_reg <= dec_colortype;
        owidth_reg     <= dec_width;
        oheight_reg    <= dec_height;
        exp_reg        <= PNG_EXP_BITS'(dec_width) * PNG_EXP_BITS'(dec_height);
        pcnt_reg       <= '0;
        // A frame nobody was granted for keeps the previous owner and is flagged.
        if (q_empty) begin
          tag_err_reg <= 1'b1;
        end else begin
          cur_chan_reg <= q_head;
        end
      end else if (dec_ovalid) begin
        pcnt_reg        <= pcnt_inc;
        oframe_done_reg <= (exp_reg != '0) && (pcnt_inc == exp_reg);
      end
    end
  end

  assign onewframe   = onewframe_reg;
  assign ocolortype  = ocolortype_reg;
  assign owidth      = owidth_reg;
  assign oheight     = oheight_reg;
  assign ovalid      = ovalid_reg;
  assign opixel      = opixel_reg;
  assign ochan       = cur_chan_reg;
  assign oframe_done = oframe_done_reg;
  assign tag_err     = tag_err_reg;

endmodule

// File: tb/tb_png_stream_arbiter.sv
// Directed bench for png_stream_arbiter: per-channel byte drivers, a byte log
// taken on the falling edge, and a hand-driven stand-in for the decoder.
module tb_png_stream_arbiter;
  import png_pkg::*;

  localparam int NCH = 4;
  localparam int CW  = 2;

  logic             clk, rst;
  logic [NCH-1:0]   req_valid, req_ready, req_last;
  logic [NCH*8-1:0] req_byte;
  logic             dec_ivalid, dec_iready;
  logic [7:0]       dec_ibyte;
  logic             dec_newframe;
  logic [1:0]       dec_colortype;
  logic [13:0]      dec_width;
  logic [31:0]      dec_height;
  logic             dec_ovalid;
  logic [31:0]      dec_pixel;
  logic             onewframe;
  logic [1:0]       ocolortype;
  logic [13:0]      owidth;
  logic [31:0]      oheight;
  logic             ovalid;
  logic [31:0]      opixel;
  logic [CW-1:0]    ochan;
  logic             oframe_done, busy, tag_err;

  int errors = 0;
  int checks = 0;

  logic [8:0]     ch_q [NCH][$];
  logic [7:0]     got_q[$];
  int             gch_q[$];
  logic [NCH-1:0] acc_mask;
  int             mon_idx;

  logic [7:0] e2_byte [5] = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21};
  int         e2_chan [5] = '{0, 0, 0, 1, 1};

  png_stream_arbiter #(.NCH(NCH), .TAGQ_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_byte(req_byte), .req_last(req_last),
    .dec_ivalid(dec_ivalid), .dec_iready(dec_iready), .dec_ibyte(dec_ibyte),
    .dec_newframe(dec_newframe), .dec_colortype(dec_colortype), .dec_width(dec_width),
    .dec_height(dec_height), .dec_ovalid(dec_ovalid), .dec_pixel(dec_pixel),
    .onewframe(onewframe), .ocolortype(ocolortype), .owidth(owidth), .oheight(oheight),
    .ovalid(ovalid), .opixel(opixel), .ochan(ochan), .oframe_done(oframe_done),
    .busy(busy), .tag_err(tag_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(int c, logic [7:0] b0, int n);
    for (int i = 0; i < n; i++) begin
      ch_q[c].push_back({(i == n - 1), 8'(b0 + 8'(i))});
    end
  endtask

  task automatic wait_bytes(string tag, int n);
    for (int k = 0; k < 60 && got_q.size() < n; k++) tick();
    chk(tag, got_q.size(), n);
  endtask

  task automatic frame(logic [13:0] w, logic [31:0] h, logic [1:0] ct);
    dec_newframe  = 1'b1;
    dec_width     = w;
    dec_height    = h;
    dec_colortype = ct;
    tick();
    dec_newframe  = 1'b0;
  endtask

  // Byte log: whatever the decoder accepts, plus which ready line was up.
  always @(negedge clk) begin
    acc_mask = req_valid & req_ready;
    if (dec_ivalid && dec_iready) begin
      mon_idx = -1;
      for (int c = 0; c < NCH; c++) if (req_ready[c]) mon_idx = c;
      got_q.push_back(dec_ibyte);
      gch_q.push_back(mon_idx);
    end
  end

  // Per-channel sources: retire an accepted head, then present the next one.
  initial begin
    req_valid = '0;
    req_byte  = '0;
    req_last  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int c = 0; c < NCH; c++) begin
        if (acc_mask[c] && ch_q[c].size() > 0) void'(ch_q[c].pop_front());
        if (ch_q[c].size() > 0) begin
          req_valid[c]       = 1'b1;
          req_byte[8*c +: 8] = ch_q[c][0][7:0];
          req_last[c]        = ch_q[c][0][8];
        end else begin
          req_valid[c]       = 1'b0;
          req_byte[8*c +: 8] = 8'h00;
          req_last[c]        = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; dec_iready = 1'b0; dec_newframe = 1'b0; dec_colortype = '0;
    dec_width = '0; dec_height = '0; dec_ovalid = 1'b0; dec_pixel = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_dec_ivalid", dec_ivalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tag_err", tag_err, 0);
    chk("rst_ochan", ochan, 0);
    chk("rst_ovalid", ovalid, 0);
    chk("rst_oframe_done", oframe_done, 0);
    tick(); tick();
    rst = 1'b0;
    dec_iready = 1'b1;
    tick();

    // Single 3-byte file on ch2.
    got_q.delete(); gch_q.delete();
    send(2, 8'hA1, 3);
    tick();
    chk("t1_grant_cycle_ivalid", dec_ivalid, 0);
    chk("t1_grant_cycle_ready", req_ready, 0);
    tick();
    chk("t1_stream_ivalid", dec_ivalid, 1);
    chk("t1_stream_ibyte", dec_ibyte, 8'hA1);
    chk("t1_stream_ready", req_ready, 4'b0100);
    chk("t1_busy", busy, 1);
    wait_bytes("t1_count", 3);
    chk("t1_b1", got_q[1], 8'hA2);
    chk("t1_b2", got_q[2], 8'hA3);
    chk("t1_state_idle", dut.state_reg, IDLE);
    chk("t1_rr_ptr", dut.rr_ptr_reg, 3);

    // ch0 and ch1 together: whole files, ch0 first.
    got_q.delete(); gch_q.delete();
    send(0, 8'h10, 3);
    send(1, 8'h20, 2);
    wait_bytes("t2_count", 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t2_byte%0d", i), got_q[i], e2_byte[i]);
      chk($sformatf("t2_chan%0d", i), gch_q[i], e2_chan[i]);
    end
    chk("t2_rr_ptr", dut.rr_ptr_reg, 2);

    // Frame 1x1 belongs to ch2; its only pixel completes it.
    frame(14'd1, 32'd1, 2'd2);
    chk("t3_onewframe", onewframe, 1);
    chk("t3_ochan", ochan, 2);
    chk("t3_owidth", owidth, 1);
    chk("t3_ocolortype", ocolortype, 2);
    dec_ovalid = 1'b1; dec_pixel = 32'hDEADBEEF;
    #1;
    chk("t3_ovalid_latency", ovalid, 0);
    tick();
    dec_ovalid = 1'b0;
    chk("t3_ovalid", ovalid, 1);
    chk("t3_opixel", opixel, 32'hDEADBEEF);
    chk("t3_done", oframe_done, 1);
    tick();
    chk("t3_done_clear", oframe_done, 0);
    chk("t3_onewframe_clear", onewframe, 0);

    // Frame 4x2 belongs to ch0: done on the 8th pixel only, 9th passes.
    frame(14'd4, 32'd2, 2'd3);
    chk("t4_ochan", ochan, 0);
    chk("t4_oheight", oheight, 2);
    for (int i = 0; i < 9; i++) begin
      dec_ovalid = 1'b1;
      dec_pixel  = 32'h01020300 + i;
      tick();
      chk($sformatf("t4_opixel%0d", i), opixel, 32'h01020300 + i);
      chk($sformatf("t4_done%0d", i), oframe_done, (i == 7));
    end
    dec_ovalid = 1'b0;
    tick();
    chk("t4_ovalid_off", ovalid, 0);

    // Zero-width frame belongs to ch1: pixels flow, never a done.
    frame(14'd0, 32'd5, 2'd0);
    chk("t5_ochan", ochan, 1);
    dec_ovalid = 1'b1; dec_pixel = 32'h55;
    tick();
    dec_ovalid = 1'b0;
    chk("t5_ovalid", ovalid, 1);
    chk("t5_no_done", oframe_done, 0);

    // Back-pressure toggling on ch3.
    got_q.delete(); gch_q.delete();
    send(3, 8'h30, 4);
    for (int k = 0; k < 14; k++) begin
      tick();
      dec_iready = (k % 2 == 0);
      #1;
      if (dut.state_reg == STREAM) chk("t6_ready_mirror", req_ready, {dec_iready, 3'b000});
    end
    dec_iready = 1'b1;
    wait_bytes("t6_count", 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t6_byte%0d", i), got_q[i], 8'h30 + i);
    for (int i = 0; i < 3; i++) tick();
    chk("t6_no_dup", got_q.size(), 4);

    // Fill the tag queue with four files, then a fifth request must wait.
    frame(14'd1, 32'd1, 2'd0);
    chk("t7_pop_ochan", ochan, 3);
    got_q.delete(); gch_q.delete();
    for (int c = 0; c < 4; c++) send(c, 8'h40 + 8'(c), 1);
    wait_bytes("t7_count", 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t7_order%0d", i), gch_q[i], i);
    send(1, 8'h50, 1);
    for (int i = 0; i < 4; i++) tick();
    chk("t7_full_ivalid", dec_ivalid, 0);
    chk("t7_full_ready", req_ready, 0);
    chk("t7_full_busy", busy, 1);
    chk("t7_full_nobyte", got_q.size(), 4);
    frame(14'd1, 32'd1, 2'd0);
    chk("t7_pop_ochan0", ochan, 0);
    chk("t7_grant_pending", dec_ivalid, 0);
    tick();
    chk("t7_grant_ivalid", dec_ivalid, 1);
    chk("t7_grant_ready", req_ready, 4'b0010);
    chk("t7_grant_byte", dec_ibyte, 8'h50);
    wait_bytes("t7_fifth", 5);

    // Drain the queue in grant order, then pop it empty.
    frame(14'd1, 32'd1, 2'd0); chk("t8_ochan_a", ochan, 1);
    frame(14'd1, 32'd1, 2'd0); chk("t8_ochan_b", ochan, 2);
    frame(14'd1, 32'd1, 2'd0); chk("t8_ochan_c", ochan, 3);
    frame(14'd1, 32'd1, 2'd0); chk("t8_ochan_d", ochan, 1);
    chk("t8_tag_err_before", tag_err, 0);
    frame(14'd1, 32'd1, 2'd0);
    chk("t8_tag_err", tag_err, 1);
    chk("t8_ochan_held", ochan, 1);
    tick();
    chk("t8_tag_err_sticky", tag_err, 1);
    chk("t8_idle_busy", busy, 0);

    // Reset in the middle of a file.
    send(2, 8'h60, 5);
    for (int k = 0; k < 10 && !dec_ivalid; k++) tick();
    chk("t9_streaming", dec_ivalid, 1);
    rst = 1'b1;
    ch_q[2].delete();
    #1;
    chk("t9_rst_ready", req_ready, 0);
    chk("t9_rst_ivalid", dec_ivalid, 0);
    chk("t9_rst_tag_err", tag_err, 0);
    chk("t9_rst_busy", busy, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("t9_rr_ptr", dut.rr_ptr_reg, 0);
    chk("t9_state", dut.state_reg, IDLE);
    chk("t9_ivalid_after", dec_ivalid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
